// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types and defaults for the memory arbiter   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STREAK_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_grant : combinational IF/DM grant selection              |
// | Fairness enabled by MEM_ARB_FAIR_EN, otherwise strict DM priority|
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic                if_req_i,
    input  logic                dm_req_i,
`ifdef MEM_ARB_FAIR_EN
    input  logic [STREAK_W-1:0] streak_i,
`endif
    output logic                gnt_if_o,
    output logic                gnt_dm_o
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_check
        $error("mem_arb_grant: STARVE_LIMIT must be within 1..15");
    end

`ifdef MEM_ARB_FAIR_EN
    localparam logic [STREAK_W-1:0] LIMIT_C = STREAK_W'(STARVE_LIMIT);
`endif

    always_comb begin
        gnt_if_o = 1'b0;
        gnt_dm_o = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        // A waiting fetch that has seen LIMIT data grants in a row jumps the queue.
        if (if_req_i && (streak_i == LIMIT_C)) begin
            gnt_if_o = 1'b1;
        end else if (dm_req_i) begin
            gnt_dm_o = 1'b1;
        end else if (if_req_i) begin
            gnt_if_o = 1'b1;
        end
`else
        if (dm_req_i) begin
            gnt_dm_o = 1'b1;
        end else if (if_req_i) begin
            gnt_if_o = 1'b1;
        end
`endif
    end

endmodule : mem_arb_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : IF/DM arbiter onto one single-port memory          |
// | Optional fairness via MEM_ARB_FAIR_EN (default: strict DM prio)  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    output logic              stall_o
);

    arb_state_e        state_q,     state_d;
    logic              gnt_is_if_q, gnt_is_if_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
`ifdef MEM_ARB_FAIR_EN
    logic [STREAK_W-1:0] streak_q,  streak_d;
`endif

    logic gnt_if;
    logic gnt_dm;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .if_req_i (if_req_i),
        .dm_req_i (dm_req_i),
`ifdef MEM_ARB_FAIR_EN
        .streak_i (streak_q),
`endif
        .gnt_if_o (gnt_if),
        .gnt_dm_o (gnt_dm)
    );

    always_comb begin
        state_d     = state_q;
        gnt_is_if_d = gnt_is_if_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef MEM_ARB_FAIR_EN
        streak_d    = streak_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_dm) begin
                    state_d     = ST_DM_BUSY;
                    gnt_is_if_d = 1'b0;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
`ifdef MEM_ARB_FAIR_EN
                    if (if_req_i) begin
                        streak_d = streak_q + 1'b1;
                    end
`endif
                end else if (gnt_if) begin
                    state_d     = ST_IF_BUSY;
                    gnt_is_if_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
`ifdef MEM_ARB_FAIR_EN
                    streak_d    = '0;
`endif
                end
            end
            ST_IF_BUSY: begin
                if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    state_d    = ST_DONE;
                end
            end
            ST_DM_BUSY: begin
                // Writes still complete, but must not disturb the read-data register.
                if (mem_ack_i) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            gnt_is_if_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef MEM_ARB_FAIR_EN
            streak_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_is_if_q <= gnt_is_if_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_FAIR_EN
            streak_q    <= streak_d;
`endif
        end
    end

    // Acks decode straight from the state register so reset clears them at once.
    assign mem_req_o   = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = (state_q == ST_DONE) &&  gnt_is_if_q;
    assign dm_ack_o    = (state_q == ST_DONE) && !gnt_is_if_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign stall_o     = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : directed self-checking bench for mem_arbiter    |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              stall_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0;
        dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        step(); step();
        n_checks++; if (mem_req_o !== 1'b0)  begin n_errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req_o); end
        n_checks++; if (mem_we_o !== 1'b0)   begin n_errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we_o); end
        n_checks++; if (mem_addr_o !== '0)   begin n_errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr_o); end
        n_checks++; if (mem_wdata_o !== '0)  begin n_errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata_o); end
        n_checks++; if ({if_ack_o, dm_ack_o} !== 2'b00) begin n_errors++; $display("FAIL rst_acks got %b exp 00", {if_ack_o, dm_ack_o}); end
        n_checks++; if (if_rdata_o !== '0 || dm_rdata_o !== '0) begin n_errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", if_rdata_o, dm_rdata_o); end
        n_checks++; if (stall_o !== 1'b0)    begin n_errors++; $display("FAIL rst_stall got %b exp 0", stall_o); end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL fetch_stall_N got %b exp 1", stall_o); end
        step();
        n_checks++; if ({mem_req_o, mem_we_o} !== 2'b10 || mem_addr_o !== 32'h40) begin
            n_errors++; $display("FAIL fetch_busy got req=%b we=%b addr=%h exp req=1 we=0 addr=00000040", mem_req_o, mem_we_o, mem_addr_o); end
        n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL fetch_stall_N1 got %b exp 1", stall_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C010004;
        step();
        mem_ack_i = 1'b0;
        n_checks++; if (if_ack_o !== 1'b1 || dm_ack_o !== 1'b0) begin n_errors++; $display("FAIL fetch_ack got if=%b dm=%b exp if=1 dm=0", if_ack_o, dm_ack_o); end
        n_checks++; if (if_rdata_o !== 32'h8C010004) begin n_errors++; $display("FAIL fetch_rdata got %h exp 8c010004", if_rdata_o); end
        n_checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin n_errors++; $display("FAIL fetch_done got stall=%b req=%b exp 0/0", stall_o, mem_req_o); end
        if_req_i = 1'b0;
        step();
        n_checks++; if (if_ack_o !== 1'b0) begin n_errors++; $display("FAIL fetch_ack_pulse got %b exp 0", if_ack_o); end
    endtask

    task automatic test_contention();
        if_req_i = 1'b1; if_addr_i = 32'h80;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
        step();
        n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_errors++; $display("FAIL cont_dm_first got req=%b addr=%h exp 1/00000100", mem_req_o, mem_addr_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
        step();
        mem_ack_i = 1'b0;
        n_checks++; if ({dm_ack_o, if_ack_o, mem_req_o} !== 3'b100) begin n_errors++; $display("FAIL cont_dm_done got dm=%b if=%b req=%b exp 1 0 0", dm_ack_o, if_ack_o, mem_req_o); end
        n_checks++; if (dm_rdata_o !== 32'h11112222) begin n_errors++; $display("FAIL cont_dm_rdata got %h exp 11112222", dm_rdata_o); end
        dm_req_i = 1'b0;
        step();
        n_checks++; if (mem_req_o !== 1'b0) begin n_errors++; $display("FAIL cont_no_grant_in_done got %b exp 0", mem_req_o); end
        step();
        n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 || mem_we_o !== 1'b0) begin
            n_errors++; $display("FAIL cont_if_second got req=%b addr=%h we=%b exp 1/00000080/0", mem_req_o, mem_addr_o, mem_we_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h33334444;
        step();
        mem_ack_i = 1'b0;
        n_checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h33334444 || dm_rdata_o !== 32'h11112222) begin
            n_errors++; $display("FAIL cont_if_done got ack=%b if_rdata=%h dm_rdata=%h exp 1/33334444/11112222", if_ack_o, if_rdata_o, dm_rdata_o); end
        if_req_i = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mem_req_o, mem_we_o} !== 2'b11 || mem_addr_o !== 32'h200 || mem_wdata_o !== 32'hDEADBEEF || dm_ack_o !== 1'b0) begin
                n_errors++; $display("FAIL wait_stable[%0d] got req=%b we=%b addr=%h wdata=%h ack=%b exp 1 1 00000200 deadbeef 0",
                                     i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dm_ack_o);
            end
            step();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBADBAD00;
        step();
        mem_ack_i = 1'b0;
        n_checks++; if (dm_ack_o !== 1'b1) begin n_errors++; $display("FAIL wait_ack got %b exp 1", dm_ack_o); end
        n_checks++; if (dm_rdata_o !== 32'h11112222) begin n_errors++; $display("FAIL write_keeps_rdata got %h exp 11112222", dm_rdata_o); end
        dm_req_i = 1'b0; dm_we_i = 1'b0;
        step();
        n_checks++; if (dm_ack_o !== 1'b0) begin n_errors++; $display("FAIL wait_ack_pulse got %b exp 0", dm_ack_o); end
    endtask

    task automatic test_ack_ignored();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
        step();
        mem_ack_i = 1'b0;
        step();
        n_checks++;
        if ({mem_req_o, if_ack_o, dm_ack_o} !== 3'b000 || if_rdata_o !== 32'h33334444 || dm_rdata_o !== 32'h11112222) begin
            n_errors++; $display("FAIL idle_ack_ignored got req=%b ifa=%b dma=%b if_rdata=%h dm_rdata=%h exp 0 0 0 33334444 11112222",
                                 mem_req_o, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o);
        end
    endtask

    task automatic test_arbitration_streak();
        bit exp_if [6];
        bit got_if;
        bit seen;
`ifdef MEM_ARB_FAIR_EN
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
        for (int k = 0; k < 6; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 4 && !seen; t++) begin
                step();
                if (mem_req_o === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (!seen) begin
                n_errors++; $display("FAIL streak_grant_timeout[%0d] got no mem_req exp mem_req within 4 cycles", k);
            end else begin
                got_if = (mem_addr_o === 32'h40);
                if (got_if !== exp_if[k]) begin
                    n_errors++; $display("FAIL streak_order[%0d] got if_grant=%b exp %b", k, got_if, exp_if[k]);
                end
                mem_ack_i = 1'b1; mem_rdata_i = 32'h1000 + k;
                step();
                mem_ack_i = 1'b0;
                n_checks++;
                if ({if_ack_o, dm_ack_o} !== {exp_if[k], ~exp_if[k]}) begin
                    n_errors++; $display("FAIL streak_ack[%0d] got if=%b dm=%b exp if=%b dm=%b", k, if_ack_o, dm_ack_o, exp_if[k], ~exp_if[k]);
                end
            end
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid_op();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400;
        step();
        n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400) begin n_errors++; $display("FAIL midrst_busy got req=%b addr=%h exp 1/00000400", mem_req_o, mem_addr_o); end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o} !== 4'b0000 || mem_addr_o !== '0 || mem_wdata_o !== '0 || if_rdata_o !== '0 || dm_rdata_o !== '0) begin
            n_errors++; $display("FAIL midrst_async got req=%b we=%b ifa=%b dma=%b addr=%h wdata=%h ifr=%h dmr=%h exp all zero",
                                 mem_req_o, mem_we_o, if_ack_o, dm_ack_o, mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o);
        end
        dm_req_i = 1'b0;
        step();
        rst_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        step();
        mem_ack_i = 1'b0;
        step();
        n_checks++;
        if ({mem_req_o, dm_ack_o, if_ack_o} !== 3'b000 || dm_rdata_o !== '0) begin
            n_errors++; $display("FAIL midrst_late_ack got req=%b dma=%b ifa=%b dmr=%h exp 0 0 0 00000000", mem_req_o, dm_ack_o, if_ack_o, dm_rdata_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_wait_states();
        test_ack_ignored();
        test_arbitration_streak();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
